// File: rtl/gemm_issue_if.sv
// gemm_issue_if: decode-side request, accelerator command/completion and status bundle.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready; gemm_stall holds the core pipeline.
interface gemm_issue_if #(
  parameter int CNT_W = 16
);
  logic             is_gemm;
  logic             flush;
  logic [2:0]       func3;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_arg;
  logic             gemm_done;
  logic             gemm_stall;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;
  logic             timeout_err;

  // Core pipeline plus accelerator side: drives requests, ready and completion.
  modport master (
    output is_gemm, flush, func3, rs1_data, rs2_data, cmd_ready, gemm_done,
    input  cmd_valid, cmd_op, cmd_addr, cmd_arg, gemm_stall, busy, done_cnt, timeout_err
  );

  // Issue unit side.
  modport slave (
    input  is_gemm, flush, func3, rs1_data, rs2_data, cmd_ready, gemm_done,
    output cmd_valid, cmd_op, cmd_addr, cmd_arg, gemm_stall, busy, done_cnt, timeout_err
  );
endinterface

// File: rtl/gemm_issue.sv
// gemm_issue: captures one GEMM instruction, issues it to the accelerator, stalls the core until completion.
// Latency: capture edge to DONE is 3 cycles minimum (ISSUE, WAIT, DONE); optional WAIT watchdog under GEMM_TIMEOUT_EN.
// Backpressure: cmd_* held stable while cmd_ready is low; gemm_stall holds the pipeline through ISSUE and WAIT.
module gemm_issue #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  gemm_issue_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [2:0]       cmd_op_q, cmd_op_d;
  logic [31:0]      cmd_addr_q, cmd_addr_d;
  logic [31:0]      cmd_arg_q, cmd_arg_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

`ifdef GEMM_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog_q;
  logic            tmo_hit;
  logic            timeout_err_q;
`else
  // Watchdog depth only matters when the watchdog is built in.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and datapath updates; a captured command is committed, so flush only matters in IDLE.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_arg_d   = cmd_arg_q;
    done_cnt_d  = done_cnt_q;
`ifdef GEMM_TIMEOUT_EN
    tmo_hit     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.is_gemm && !bus.flush) begin
          state_d     = S_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_op_d    = bus.func3;
          cmd_addr_d  = bus.rs1_data;
          cmd_arg_d   = bus.rs2_data;
        end
      end
      S_ISSUE: begin
        if (cmd_valid_q && bus.cmd_ready) begin
          state_d     = S_WAIT;
          cmd_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (bus.gemm_done) begin
          state_d = S_DONE;
        end
`ifdef GEMM_TIMEOUT_EN
        // A completion arriving on the last allowed cycle takes priority over the watchdog.
        else if (wdog_q == WD_LAST) begin
          state_d = S_DONE;
          tmo_hit = 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d    = S_IDLE;
        done_cnt_d = done_cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and command registers; reset abandons any in-flight command without counting it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 3'd0;
      cmd_addr_q  <= 32'd0;
      cmd_arg_q   <= 32'd0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_arg_q   <= cmd_arg_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

`ifdef GEMM_TIMEOUT_EN
  // Watchdog counts elapsed WAIT cycles; held at zero outside WAIT so every entry starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else if (state_q == S_WAIT) begin
      wdog_q <= wdog_q + WD_W'(1);
    end else begin
      wdog_q <= '0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err_q <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_op     = cmd_op_q;
  assign bus.cmd_addr   = cmd_addr_q;
  assign bus.cmd_arg    = cmd_arg_q;
  assign bus.done_cnt   = done_cnt_q;
  assign bus.busy       = (state_q != S_IDLE);
  // Combinational so the core stalls in the same cycle the instruction is presented.
  assign bus.gemm_stall = ((state_q == S_IDLE) && bus.is_gemm && !bus.flush)
                        || (state_q == S_ISSUE) || (state_q == S_WAIT);

endmodule
